seg7_encoder: RTL and testbench

Seven-segment pattern encoder: the inverse of the team's hex-to-segment decoder. It samples an active-low 7-segment bus, where bit 6 is segment a and bit 0 is segment g, and filters out glitches by requiring the pattern to be stable for a set number of cycles. When a new stable pattern appears, it reports the matching hex nibble with a one-cycle valid pulse. It sits on the display-monitor path so the bench and self-check logic can read back what a display driver is actually showing.

---
 rtl/seg7_if.sv | 30 +++
 rtl/seg7_encoder.sv | 164 ++++++++++++++++
 tb/tb_seg7_encoder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_if.sv
// Seven-segment monitor bus: the sampled segment lines going in and the
// decoded glyph report coming back out.
interface seg7_if;
    logic [6:0] seg_in;     // {a,b,c,d,e,f,g}, active-low
    logic [3:0] hex_out;    // nibble of last committed pattern
    logic       valid;      // one-cycle commit pulse
    logic       err;        // last commit was not a recognised glyph
    logic       blank;      // last commit was all segments off
    logic [7:0] err_count;  // saturating count of invalid commits

    // Side that drives the segment lines and consumes the report.
    modport master (
        output seg_in,
        input  hex_out,
        input  valid,
        input  err,
        input  blank,
        input  err_count
    );

    // The encoder itself.
    modport slave (
        input  seg_in,
        output hex_out,
        output valid,
        output err,
        output blank,
        output err_count
    );
endinterface

// File: rtl/seg7_encoder.sv
// Seven-segment pattern encoder. Samples an active-low segment bus, waits for
// a pattern to hold for STABLE_CYCLES consecutive samples, and reports each
// newly stable pattern once as a hex nibble with a single-cycle valid pulse.
// A glitch that settles back onto the already reported pattern is swallowed.
module seg7_encoder #(
    parameter int unsigned STABLE_CYCLES = 4   // legal range 1..15
) (
    input  logic   clk,
    input  logic   reset,
    seg7_if.slave  bus
);

    localparam logic [3:0] STABLE    = 4'(STABLE_CYCLES);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        SETTLE = 1'b0,   // candidate still accumulating samples
        LOCKED = 1'b1    // candidate equals reported pattern, watching for change
    } state_t;

    // Decode result of one segment pattern.
    typedef struct packed {
        logic       blank;
        logic       err;
        logic [3:0] hex;
    } decode_t;

    // Map a raw segment pattern to its glyph. Blank and unrecognised patterns
    // both report nibble 0 and are told apart by the blank/err flags.
    function automatic decode_t decode(input logic [6:0] s);
        decode_t d;
        d = '{blank: 1'b0, err: 1'b0, hex: 4'h0};
        case (s)
            7'h01: d.hex = 4'h0;
            7'h4F: d.hex = 4'h1;
            7'h12: d.hex = 4'h2;
            7'h06: d.hex = 4'h3;
            7'h4C: d.hex = 4'h4;
            7'h24: d.hex = 4'h5;
            7'h20: d.hex = 4'h6;
            7'h0F: d.hex = 4'h7;
            7'h00: d.hex = 4'h8;
            7'h04: d.hex = 4'h9;
            7'h08: d.hex = 4'hA;
            7'h60: d.hex = 4'hB;
            7'h31: d.hex = 4'hC;
            7'h42: d.hex = 4'hD;
            7'h30: d.hex = 4'hE;
            7'h38: d.hex = 4'hF;
            7'h7F: d.blank = 1'b1;
            default: d.err = 1'b1;
        endcase
        return d;
    endfunction

    // Input stage, stability tracker and last-reported pattern.
    logic [6:0] seg_q,  seg_d;
    logic [6:0] cand_q, cand_d;
    logic [3:0] cnt_q,  cnt_d;
    logic [6:0] rep_q,  rep_d;
    state_t     state_q, state_d;

    // Registered report outputs.
    logic [3:0] hex_q,       hex_d;
    logic       valid_q,     valid_d;
    logic       err_q,       err_d;
    logic       blank_q,     blank_d;
    logic [7:0] err_count_q, err_count_d;

    logic       commit;
    decode_t    cand_dec;

    assign seg_d    = bus.seg_in;
    assign cand_dec = decode(cand_q);

    // Stability tracker: restart on any change, otherwise count up to the threshold.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (seg_q != cand_q) begin
            cand_d = seg_q;
            cnt_d  = 4'd1;
        end else if (cnt_q < STABLE) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // FSM next state and commit decision.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            SETTLE: begin
                // Pattern has held long enough; only report it if it differs
                // from what was last reported.
                if (cnt_q == STABLE && seg_q == cand_q) begin
                    state_d = LOCKED;
                    commit  = (cand_q != rep_q);
                end
            end
            LOCKED: begin
                // cand tracks seg_q while locked, so a mismatch is a fresh change.
                if (seg_q != cand_q) begin
                    state_d = SETTLE;
                end
            end
            default: state_d = SETTLE;
        endcase
    end

    // Report registers: load on commit, otherwise hold; valid is a pure pulse.
    always_comb begin
        rep_d       = rep_q;
        hex_d       = hex_q;
        err_d       = err_q;
        blank_d     = blank_q;
        err_count_d = err_count_q;
        valid_d     = commit;
        if (commit) begin
            rep_d   = cand_q;
            hex_d   = cand_dec.hex;
            err_d   = cand_dec.err;
            blank_d = cand_dec.blank;
            if (cand_dec.err && err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    // All state; reset leaves the block locked on a blank display so an idle
    // bus right after reset never produces a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q       <= SEG_BLANK;
            cand_q      <= SEG_BLANK;
            cnt_q       <= STABLE;
            rep_q       <= SEG_BLANK;
            state_q     <= LOCKED;
            hex_q       <= 4'h0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            blank_q     <= 1'b1;
            err_count_q <= 8'd0;
        end else begin
            seg_q       <= seg_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            rep_q       <= rep_d;
            state_q     <= state_d;
            hex_q       <= hex_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            blank_q     <= blank_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.hex_out   = hex_q;
    assign bus.valid     = valid_q;
    assign bus.err       = err_q;
    assign bus.blank     = blank_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_seg7_encoder.sv
// Testbench for seg7_encoder: directed glyph table plus hand-written
// sequences for glitch rejection, saturation and reset corner cases.
module tb_seg7_encoder;

    logic clk;
    logic reset;

    seg7_if bus();

    seg7_encoder #(.STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] hex;
        logic       err;
        logic       blank;
    } vec_t;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Drive a pattern for n edges; sample 1 time unit after each edge and
    // record the number of valid cycles and the outputs seen at the last one.
    task automatic hold(input logic [6:0] p, input int n, output int pulses,
                        output logic [3:0] hx, output logic e, output logic b);
        bus.seg_in = p;
        pulses = 0;
        hx = 4'hX; e = 1'bX; b = 1'bX;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (bus.valid === 1'b1) begin
                pulses++;
                hx = bus.hex_out; e = bus.err; b = bus.blank;
            end
        end
    endtask

    // Absolute time limit so a broken design can never hang the run.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t       vecs[20];
        int         pulses;
        logic [3:0] hx;
        logic       e, b;
        int         exp_errs;
        int         first_k;
        int         bad;

        // Glyph sweep 0..F, then blank / invalid / glyph / blank entries.
        vecs[0]  = '{7'h01, 4'h0, 1'b0, 1'b0};
        vecs[1]  = '{7'h4F, 4'h1, 1'b0, 1'b0};
        vecs[2]  = '{7'h12, 4'h2, 1'b0, 1'b0};
        vecs[3]  = '{7'h06, 4'h3, 1'b0, 1'b0};
        vecs[4]  = '{7'h4C, 4'h4, 1'b0, 1'b0};
        vecs[5]  = '{7'h24, 4'h5, 1'b0, 1'b0};
        vecs[6]  = '{7'h20, 4'h6, 1'b0, 1'b0};
        vecs[7]  = '{7'h0F, 4'h7, 1'b0, 1'b0};
        vecs[8]  = '{7'h00, 4'h8, 1'b0, 1'b0};
        vecs[9]  = '{7'h04, 4'h9, 1'b0, 1'b0};
        vecs[10] = '{7'h08, 4'hA, 1'b0, 1'b0};
        vecs[11] = '{7'h60, 4'hB, 1'b0, 1'b0};
        vecs[12] = '{7'h31, 4'hC, 1'b0, 1'b0};
        vecs[13] = '{7'h42, 4'hD, 1'b0, 1'b0};
        vecs[14] = '{7'h30, 4'hE, 1'b0, 1'b0};
        vecs[15] = '{7'h38, 4'hF, 1'b0, 1'b0};
        vecs[16] = '{7'h7F, 4'h0, 1'b0, 1'b1};
        vecs[17] = '{7'h7E, 4'h0, 1'b1, 1'b0};
        vecs[18] = '{7'h12, 4'h2, 1'b0, 1'b0};
        vecs[19] = '{7'h7F, 4'h0, 1'b0, 1'b1};

        // 1: reset values, then an idle blank bus produces nothing.
        reset = 1'b1;
        bus.seg_in = 7'h7F;
        @(posedge clk); #1;
        check("reset hex_out",   32'(bus.hex_out),   32'h0);
        check("reset valid",     32'(bus.valid),     32'h0);
        check("reset err",       32'(bus.err),       32'h0);
        check("reset blank",     32'(bus.blank),     32'h1);
        check("reset err_count", 32'(bus.err_count), 32'h0);
        reset = 1'b0;
        hold(7'h7F, 20, pulses, hx, e, b);
        check("idle blank pulses", 32'(pulses),        32'd0);
        check("idle blank flag",   32'(bus.blank),     32'h1);
        check("idle hex_out",      32'(bus.hex_out),   32'h0);
        check("idle err_count",    32'(bus.err_count), 32'h0);
        exp_errs = 0;

        // 2: exact latency; pattern first sampled at edge k=1, commit at k=6.
        bus.seg_in = 7'h12;
        pulses = 0;
        first_k = -1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            if (bus.valid === 1'b1) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
        end
        check("latency first valid edge", 32'(first_k), 32'd6);
        check("latency pulse width",      32'(pulses),  32'd1);
        check("latency hex_out",          32'(bus.hex_out), 32'h2);
        check("latency err",              32'(bus.err),     32'h0);
        check("latency blank",            32'(bus.blank),   32'h0);

        // 3: short run of 06 returning to 12 is swallowed; long run reports 3.
        hold(7'h06, 3, pulses, hx, e, b);
        check("short glitch pulses", 32'(pulses), 32'd0);
        hold(7'h12, 8, pulses, hx, e, b);
        check("return to reported pulses", 32'(pulses), 32'd0);
        check("held hex after glitch",     32'(bus.hex_out), 32'h2);
        hold(7'h06, 6, pulses, hx, e, b);
        check("long run pulses", 32'(pulses), 32'd1);
        check("long run hex",    32'(hx),     32'h3);

        // 4: table-driven glyph sweep and flag vectors.
        foreach (vecs[i]) begin
            hold(vecs[i].seg, 6, pulses, hx, e, b);
            if (vecs[i].err) exp_errs++;
            check($sformatf("vec%0d seg=%02h pulses", i, vecs[i].seg), 32'(pulses), 32'd1);
            check($sformatf("vec%0d seg=%02h report", i, vecs[i].seg),
                  {26'd0, e, b, hx}, {26'd0, vecs[i].err, vecs[i].blank, vecs[i].hex});
            check($sformatf("vec%0d err_count", i), 32'(bus.err_count), 32'(exp_errs));
        end

        // 5: 300 alternating invalid commits; count saturates at 255.
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            hold((i % 2 == 0) ? 7'h7E : 7'h7D, 6, pulses, hx, e, b);
            if (exp_errs < 255) exp_errs++;
            if (pulses != 1 || e !== 1'b1 || hx !== 4'h0 || b !== 1'b0 ||
                bus.err_count !== 8'(exp_errs)) begin
                bad++;
            end
            if (i == 200) begin
                check("err_count mid-sweep", 32'(bus.err_count), 32'(exp_errs));
            end
        end
        check("invalid sweep bad commits", 32'(bad),           32'd0);
        check("err_count saturated",       32'(bus.err_count), 32'd255);
        check("err held after sweep",      32'(bus.err),       32'h1);

        // 6: reset while settling on 4C with cnt=2.
        bus.seg_in = 7'h4C;
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid-settle reset valid",     32'(bus.valid),     32'h0);
        check("mid-settle reset hex_out",   32'(bus.hex_out),   32'h0);
        check("mid-settle reset blank",     32'(bus.blank),     32'h1);
        check("mid-settle reset err",       32'(bus.err),       32'h0);
        check("mid-settle reset err_count", 32'(bus.err_count), 32'h0);
        reset = 1'b0;
        hold(7'h4C, 6, pulses, hx, e, b);
        check("after reset 4C pulses", 32'(pulses), 32'd1);
        check("after reset 4C hex",    32'(hx),     32'h4);

        // Reset in the commit cycle suppresses the pulse.
        bus.seg_in = 7'h12;
        repeat (5) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("commit-cycle reset valid", 32'(bus.valid),   32'h0);
        check("commit-cycle reset blank", 32'(bus.blank),   32'h1);
        check("commit-cycle reset hex",   32'(bus.hex_out), 32'h0);
        reset = 1'b0;
        hold(7'h7F, 8, pulses, hx, e, b);
        check("blank after reset pulses", 32'(pulses), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
